mem_arbiter: RTL and testbench

Shares one single-port synchronous word RAM between the rv32i instruction-fetch port and data port, for builds where imem and dmem are the same physical array.
- Arbitrates between the two ports with round-robin priority.
- Sequences each access through a fixed-latency read pipeline.
- Returns read data with a one-cycle ack pulse.
- Sits between the core's imem/dmem ports (core stalled by the missing ack) and the RAM macro.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the imem/dmem single-port RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 7;
  localparam int unsigned CNT_W   = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin picker; favours the port that did not own the RAM last.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output owner_t     gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt       = OWN_I;
    if (&req) begin
      gnt = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (req[1]) begin
      gnt = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and data (D) ports.
// Every transaction runs IDLE -> ISSUE -> [WAIT x LATENCY for reads] -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  owner_t             owner, last_owner, gnt;
  logic               gnt_valid;
  logic               gnt_we;
  logic               we_q;
  logic               capture;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, i_req}),
    .last_owner (last_owner),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid)
  );

  assign gnt_we  = (gnt == OWN_D) && d_we;
  // Last WAIT cycle is the one in which the RAM presents read data.
  assign capture = (state == ST_WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_d = ST_DONE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_I;
      last_owner <= OWN_I;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en <= (state_d == ST_ISSUE);
      mem_we <= (state_d == ST_ISSUE) && gnt_we;
      busy   <= (state_d != ST_IDLE);
      i_ack  <= (state_d == ST_DONE) && (owner == OWN_I);
      d_ack  <= (state_d == ST_DONE) && (owner == OWN_D);
      if ((state == ST_IDLE) && gnt_valid) begin
        owner      <= gnt;
        last_owner <= gnt;
        we_q       <= gnt_we;
        mem_addr   <= (gnt == OWN_D) ? d_addr : i_addr;
        mem_wdata  <= (gnt == OWN_D) ? d_wdata : '0;
      end
      if (capture) begin
        if (owner == OWN_I) i_rdata <= mem_rdata;
        else                d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances at LATENCY 1/2/3/7, each with its own RAM model,
// checked cycle by cycle against a transaction-level timing and data model.
module tb_mem_arbiter;

  localparam int NI = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int k);
    return (k == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(k));
  endfunction

  logic        clk = 1'b0;
  logic        rst_n   [NI];
  logic        i_req   [NI];
  logic        d_req   [NI];
  logic        d_we    [NI];
  logic [31:0] i_addr  [NI];
  logic [31:0] d_addr  [NI];
  logic [31:0] d_wdata [NI];
  logic        i_ack   [NI];
  logic        d_ack   [NI];
  logic [31:0] i_rdata [NI];
  logic [31:0] d_rdata [NI];
  logic        mem_en  [NI];
  logic        mem_we  [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        busy    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    logic [31:0] ram [16];
    logic [7:0]  vpipe;
    logic [3:0]  ipipe [8];
    logic [31:0] junk;

    mem_arbiter #(.AW(32), .DW(32), .LATENCY(LAT)) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_ack     (i_ack[g]),
      .i_rdata   (i_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    initial begin
      for (int k = 0; k < 16; k++) ram[k] = init_word(k);
      for (int k = 0; k < 8; k++) ipipe[k] = '0;
      vpipe = '0;
      junk  = 32'h0BAD_F00D;
    end

    // RAM: read data valid only LAT cycles after the mem_en cycle, junk otherwise
    always @(posedge clk) begin
      vpipe    <= {vpipe[6:0], mem_en[g] & ~mem_we[g]};
      ipipe[0] <= mem_addr[g][5:2];
      for (int k = 1; k < 8; k++) ipipe[k] <= ipipe[k-1];
      junk <= $urandom;
      if (mem_en[g] && mem_we[g]) ram[mem_addr[g][5:2]] <= mem_wdata[g];
    end

    assign mem_rdata[g] = vpipe[LAT-1] ? ram[ipipe[LAT-1]] : junk;
  end

  // Reference model state
  logic [31:0] golden [NI][16];
  bit          last_d [NI];
  logic [31:0] exp_ir [NI];
  logic [31:0] exp_dr [NI];

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, g, obs, exp);
    end
  endtask

  task automatic chk_cyc(input int g, input bit b, input bit en, input bit ia, input bit da, input string ph);
    check({ph, ".busy"},    g, 32'(busy[g]),   32'(b));
    check({ph, ".mem_en"},  g, 32'(mem_en[g]), 32'(en));
    check({ph, ".i_ack"},   g, 32'(i_ack[g]),  32'(ia));
    check({ph, ".d_ack"},   g, 32'(d_ack[g]),  32'(da));
    check({ph, ".i_rdata"}, g, i_rdata[g],     exp_ir[g]);
    check({ph, ".d_rdata"}, g, d_rdata[g],     exp_dr[g]);
    if (!en) check({ph, ".mem_we"}, g, 32'(mem_we[g]), 32'd0);
  endtask

  task automatic model_reset(input int g);
    last_d[g] = 1'b0;
    exp_ir[g] = '0;
    exp_dr[g] = '0;
  endtask

  task automatic chk_reset_outputs(input int g);
    chk_cyc(g, 0, 0, 0, 0, "rst");
    check("rst.mem_addr",  g, mem_addr[g],  32'd0);
    check("rst.mem_wdata", g, mem_wdata[g], 32'd0);
  endtask

  task automatic do_reset(input int g);
    rst_n[g] = 1'b0;
    #1;
    model_reset(g);
    chk_reset_outputs(g);
    step();
    step();
    rst_n[g] = 1'b1;
  endtask

  // Called in a cycle where the DUT is idle; runs one transaction (or one idle cycle) to completion.
  task automatic serve(input int g, input bit drop_early, input bit keep_i, input bit keep_d, output bit obs_d);
    bit          own_d, we;
    logic [31:0] addr, wd;
    int          ack_c;
    obs_d = 1'b0;
    if (!i_req[g] && !d_req[g]) begin
      chk_cyc(g, 0, 0, 0, 0, "idle0");
      step();
      chk_cyc(g, 0, 0, 0, 0, "idle1");
      return;
    end
    own_d = (i_req[g] && d_req[g]) ? !last_d[g] : d_req[g];
    last_d[g] = own_d;
    we    = own_d && d_we[g];
    addr  = own_d ? d_addr[g] : i_addr[g];
    wd    = d_wdata[g];
    ack_c = we ? 2 : lat_of(g) + 2;
    chk_cyc(g, 0, 0, 0, 0, "c0");
    for (int c = 1; c <= ack_c; c++) begin
      step();
      if (c == ack_c) begin
        if (we)         golden[g][addr[5:2]] = wd;
        else if (own_d) exp_dr[g] = golden[g][addr[5:2]];
        else            exp_ir[g] = golden[g][addr[5:2]];
        obs_d = d_ack[g];
        chk_cyc(g, 1, 0, !own_d, own_d, "ack");
        if (own_d && !keep_d) d_req[g] = 1'b0;
        if (!own_d && !keep_i) i_req[g] = 1'b0;
      end else begin
        chk_cyc(g, 1, c == 1, 0, 0, (c == 1) ? "issue" : "wait");
        if (c == 1) begin
          check("issue.mem_we",   g, 32'(mem_we[g]), 32'(we));
          check("issue.mem_addr", g, mem_addr[g],    addr);
          if (we) check("issue.mem_wdata", g, mem_wdata[g], wd);
        end
        if (c == 2 && drop_early) begin
          if (own_d) d_req[g] = 1'b0;
          else       i_req[g] = 1'b0;
        end
      end
    end
    step();
    chk_cyc(g, 0, 0, 0, 0, "post");
  endtask

  initial begin
    bit obs;
    bit exp_seq [4];
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1; exp_seq[3] = 1'b0;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; i_req[g] = 1'b0; d_req[g] = 1'b0; d_we[g] = 1'b0;
      i_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
      model_reset(g);
      for (int k = 0; k < 16; k++) golden[g][k] = init_word(k);
    end
    #1;
    for (int g = 0; g < NI; g++) chk_reset_outputs(g);
    step();
    step();
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
    step();

    // LATENCY=2 fetch of 0x10, then data write of 0x20
    i_req[1] = 1'b1; i_addr[1] = 32'h10;
    serve(1, 0, 0, 0, obs);
    check("t1.i_rdata_held", 1, i_rdata[1], 32'hDEADBEEF);
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h20; d_wdata[1] = 32'h12345678;
    serve(1, 0, 0, 0, obs);
    check("t2.d_rdata_kept", 1, d_rdata[1], 32'd0);

    // Both ports held after reset: D, I, D, I
    do_reset(0);
    i_req[0] = 1'b1; i_addr[0] = 32'h14;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      serve(0, 0, 1, 1, obs);
      check("t3.grant_order", 0, 32'(obs), 32'(exp_seq[k]));
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    step();

    // LATENCY=7 and LATENCY=1 reads
    i_req[3] = 1'b1; i_addr[3] = 32'h1C;
    serve(3, 0, 0, 0, obs);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h24;
    serve(0, 0, 0, 0, obs);

    // LATENCY=3 fetch with i_req dropped in cycle 2; then nothing pending
    i_req[2] = 1'b1; i_addr[2] = 32'h28;
    serve(2, 1, 0, 0, obs);
    serve(2, 0, 0, 0, obs);

    // Reset during WAIT of a D read aborts it; D is served first afterwards
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h14;
    step(); step(); step();
    rst_n[2] = 1'b0;
    i_req[2] = 1'b1; i_addr[2] = 32'h08;
    #1;
    model_reset(2);
    chk_reset_outputs(2);
    step();
    chk_reset_outputs(2);
    step();
    chk_reset_outputs(2);
    rst_n[2] = 1'b1;
    serve(2, 0, 0, 0, obs);
    check("t5.d_first", 2, 32'(obs), 32'd1);
    serve(2, 0, 0, 0, obs);
    check("t5.i_next", 2, 32'(obs), 32'd0);

    // Reset during ISSUE of a write: the write must not reach the RAM
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h18; d_wdata[1] = 32'hBAD0BAD0;
    step();
    check("t5w.mem_we", 1, 32'(mem_we[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    model_reset(1);
    chk_reset_outputs(1);
    d_req[1] = 1'b0;
    step(); step();
    rst_n[1] = 1'b1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h18;
    serve(1, 0, 0, 0, obs);
    check("t5w.not_written", 1, d_rdata[1], init_word(6));

    // Randomized traffic on every instance
    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < 30; n++) begin
        if (!i_req[g] && ($urandom_range(0, 3) != 0)) begin
          i_req[g]  = 1'b1;
          i_addr[g] = {$urandom} & 32'hFFFF_FFFC;
        end
        if (!d_req[g] && ($urandom_range(0, 3) != 0)) begin
          d_req[g]   = 1'b1;
          d_we[g]    = 1'($urandom_range(0, 1));
          d_addr[g]  = {$urandom} & 32'hFFFF_FFFC;
          d_wdata[g] = $urandom;
        end
        serve(g, 1'($urandom_range(0, 7) == 0), 0, 0, obs);
      end
      i_req[g] = 1'b0; d_req[g] = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
